// File: rtl/direction_ctl_pkg.sv
// Shared constants for the keyboard-driven direction controller:
// one-hot direction codes, PS/2 set-2 scan codes and decoder state type.
package direction_ctl_pkg;

  localparam int unsigned STEP_CYCLES_DEFAULT = 15165696;

  localparam logic [4:0] DIR_RIGHT = 5'b00001;
  localparam logic [4:0] DIR_DOWN  = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_UP    = 5'b01000;
  localparam logic [4:0] DIR_STOP  = 5'b10000;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Stop is never treated as the opposite of anything.
  function automatic logic is_opposite(input logic [4:0] a, input logic [4:0] b);
    return ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

endpackage

// File: rtl/direction_ctl_step_timer.sv
// Free-running step counter; step is high during the last cycle of each period.
module step_timer
  import direction_ctl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic step
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign step = w_last;

endmodule

// File: rtl/direction_ctl.sv
// Decodes PS/2 arrow/space make codes into a pending request and commits it
// to the registered direction once per step period, rejecting reversals.
module direction_ctl
  import direction_ctl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] direction,
  output logic       step
);

  dec_state_t r_state;
  dec_state_t w_state_next;
  logic       w_req_valid;
  logic [4:0] w_req_dir;
  logic [4:0] r_pending;
  logic [4:0] r_direction;
  logic       w_step;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .step  (w_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (rx_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      w_state_next = ST_EXT;
          else if (rx_data == SC_BRK) w_state_next = ST_BRK;
          else                        w_state_next = ST_IDLE;
        end
        ST_EXT:     w_state_next = (rx_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     w_state_next = ST_IDLE;
        ST_EXT_BRK: w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_req_valid = 1'b0;
    w_req_dir   = DIR_STOP;
    if (rx_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (rx_data == SC_SPACE) begin
            w_req_valid = 1'b1;
            w_req_dir   = DIR_STOP;
          end
        end
        ST_EXT: begin
          unique case (rx_data)
            SC_RIGHT: begin w_req_valid = 1'b1; w_req_dir = DIR_RIGHT; end
            SC_DOWN:  begin w_req_valid = 1'b1; w_req_dir = DIR_DOWN;  end
            SC_LEFT:  begin w_req_valid = 1'b1; w_req_dir = DIR_LEFT;  end
            SC_UP:    begin w_req_valid = 1'b1; w_req_dir = DIR_UP;    end
            default:  w_req_valid = 1'b0;
          endcase
        end
        default: w_req_valid = 1'b0;
      endcase
    end
  end

  // Commit samples the pre-edge pending value, so a request landing in the
  // step cycle only takes effect at the following step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending   <= DIR_STOP;
      r_direction <= DIR_STOP;
    end else begin
      if (w_req_valid) begin
        r_pending <= w_req_dir;
      end
      if (w_step && !is_opposite(r_pending, r_direction)) begin
        r_direction <= r_pending;
      end
    end
  end

  assign direction = r_direction;
  assign step      = w_step;

endmodule

// File: tb/tb_direction_ctl.sv
// Randomized scoreboard bench: a scan-code/step model pushes expected commits,
// a negedge monitor pops them whenever the DUT pulses step.
module tb_direction_ctl;

  localparam int STEP = 8;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] direction;
  logic       step;

  direction_ctl #(.STEP_CYCLES(STEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .direction (direction),
    .step      (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] dir;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cyc = 0;

  // Reference model: directions as indices 0 right,1 down,2 left,3 up,4 stop.
  initial begin
    int        pend;
    int        cur;
    bit [7:0]  seq[$];
    exp_t      e;
    pend = 4;
    cur  = 4;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_cyc = 0;
        seq.delete();
        pend = 4;
        cur  = 4;
      end else begin
        if (m_cyc % STEP == STEP - 1) begin
          if (!(pend < 4 && cur < 4 && (pend + 2) % 4 == cur)) cur = pend;
          e.cyc = m_cyc;
          e.dir = 5'(1 << cur);
          q.push_back(e);
        end
        if (rx_valid) begin
          bit [7:0] b;
          b = rx_data;
          seq.push_back(b);
          if (!((seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
                (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0))) begin
            if (seq.size() == 1 && b == 8'h29) pend = 4;
            else if (seq.size() == 2 && seq[0] == 8'hE0) begin
              case (b)
                8'h74: pend = 0;
                8'h72: pend = 1;
                8'h6B: pend = 2;
                8'h75: pend = 3;
                default: ;
              endcase
            end
            seq.delete();
          end
        end
        m_cyc++;
      end
    end
  end

  // Monitor
  initial begin
    bit         step_seen;
    int         step_idx;
    int         mcnt;
    logic [4:0] exp_dir;
    exp_t       e;
    step_seen = 0;
    step_idx  = 0;
    mcnt      = 0;
    exp_dir   = 5'b10000;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n_vec++;
        if (direction !== 5'b10000 || step !== 1'b0) begin
          n_err++;
          $display("FAIL reset_state got dir=%b step=%b exp dir=10000 step=0", direction, step);
        end
        q.delete();
        mcnt      = 0;
        step_seen = 0;
        exp_dir   = 5'b10000;
      end else begin
        if (step_seen) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_step at cyc=%0d got step=1 exp no step", step_idx);
          end else begin
            e = q.pop_front();
            exp_dir = e.dir;
            if (e.cyc != step_idx) begin
              n_err++;
              $display("FAIL step_timing got cyc=%0d exp cyc=%0d", step_idx, e.cyc);
            end
            $display("step cyc=%0d dir=%b exp=%b", step_idx, direction, exp_dir);
          end
        end else if (q.size() != 0) begin
          n_vec++;
          n_err++;
          e = q.pop_front();
          exp_dir = e.dir;
          $display("FAIL missed_step got no step exp step at cyc=%0d", e.cyc);
        end
        n_vec++;
        if (direction !== exp_dir) begin
          n_err++;
          $display("FAIL direction cyc=%0d got=%b exp=%b", mcnt, direction, exp_dir);
        end
        step_seen = (step === 1'b1);
        step_idx  = mcnt;
        mcnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Strobe a byte exactly in a step cycle, as predicted by the model counter.
  task automatic send_in_step(input logic [7:0] b);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (reset && (m_cyc % STEP != STEP - 1) && guard < 4 * STEP);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] pool[8];
    pool = '{8'hE0, 8'hF0, 8'h74, 8'h72, 8'h6B, 8'h75, 8'h29, 8'h1C};
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    reset = 1'b1;

    idle(3 * STEP + 4);                         // idle: stop held
    send(8'hE0); send(8'h74); idle(12);         // right
    send(8'hE0); send(8'h6B); idle(20);         // reversal rejected
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h72); idle(20);
    send(8'h29); idle(12);                      // stop
    send(8'hE0); send(8'hF0); send(8'h74); idle(20);
    send(8'hE0); send(8'h75); idle(12);
    send(8'h29); idle(12);
    send(8'hE0); send_in_step(8'h72); idle(20); // request in step cycle
    send(8'hE0); do_reset(2); send(8'h74); idle(20);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        idle(3);
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        send(8'($urandom));
      end else begin
        send(pool[$urandom_range(0, 7)]);
      end
      idle($urandom_range(0, 6));
    end

    idle(2 * STEP);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d queued exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/direction_ctl.md
DIRECTION_CTL -- requirements
Module: direction_ctl

Interface
REQ-001 Parameter STEP_CYCLES, default 15165696: clock cycles per snake step; must equal the step period of the downstream move stage.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  keyboard scan-code byte (PS/2 set 2).
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data valid when high.
REQ-006 direction  output  5  registered one-hot command to move stage: 00001 right, 00010 down, 00100 left, 01000 up, 10000 stop.
REQ-007 step  output  1  one-cycle pulse in the cycle direction is (re)committed.

Function
REQ-008 Decoder FSM states SHALL be IDLE, EXT, BRK and EXT_BRK; transitions occur only on cycles with rx_valid=1.
REQ-009 IDLE: byte E0 -> EXT; F0 -> BRK; 29 (space) -> request stop, stay IDLE; any other byte -> IDLE, no request.
REQ-010 EXT: F0 -> EXT_BRK; 74 -> request right; 72 -> request down; 6B -> request left; 75 -> request up; any other byte -> no request; every exit except F0 returns to IDLE.
REQ-011 BRK and EXT_BRK: next byte is consumed without a request -> IDLE (key releases ignored).
REQ-012 A request SHALL overwrite a 5-bit pending register; last request in a step period wins.
REQ-013 Free-running step counter SHALL count 0..STEP_CYCLES-1 and wrap; step=1 in the cycle the counter equals STEP_CYCLES-1.
REQ-014 On the clock edge ending the step=1 cycle, direction SHALL load pending, unless pending is the exact opposite of the current direction (right/left, up/down), in which case direction holds.
REQ-015 Stop is never an opposite: any arrow from stop and stop from any arrow are accepted.
REQ-016 Request and step in the same cycle: commit uses pending as it was before that cycle; new request lands in pending for the next step.
REQ-017 direction SHALL change only on the edge ending a step=1 cycle, so it is stable for a full period when move samples it.
REQ-018 rx_valid=0 cycles SHALL not alter FSM state or pending.

Reset
REQ-019 reset=0 SHALL immediately force: FSM IDLE, pending 10000, direction 10000, counter 0, step 0.
REQ-020 Reset mid-sequence (e.g., after E0) SHALL discard the partial code; first byte after release is decoded from IDLE.
REQ-021 The counter SHALL be released from reset together with the move stage, keeping both step counters aligned.

Structure
REQ-022 Shared package: direction one-hot codes (DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP, DIR_STOP), scan-code constants (E0, F0, 74, 72, 6B, 75, 29), default STEP_CYCLES.
REQ-023 One sub-module, step_timer (counter + step pulse, parameter STEP_CYCLES); decoder FSM and commit logic in direction_ctl.

Verification (STEP_CYCLES=8)
REQ-024 Release reset, no bytes -> direction=10000 for 3 steps; step pulses every 8 cycles.
REQ-025 Bytes E0,74 -> direction=00001 after next step pulse; then E0,6B -> direction stays 00001 (reversal rejected).
REQ-026 Bytes E0,75 then E0,72 within one period, from right -> direction=00010 (last wins, not opposite of right).
REQ-027 E0,F0,74 (right release) from stop -> direction stays 10000; then 29 with direction up -> 10000 next step.
REQ-028 E0,72 with 72 strobed in the step cycle -> no change that step, 00010 at following step.
REQ-029 E0 then reset=0 for 2 cycles, then 74 -> no request, direction=10000, FSM IDLE.
